// File: rtl/arbiter_rr_n.sv
// N-requester round-robin arbiter with registered one-hot grant and an optional
// grant-hold limit that forces rotation when a long-running owner starves others.
module arbiter_rr_n #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   request,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid,
    output logic           expired
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           valid_q, valid_d;
    logic           expired_q, expired_d;
    logic [N-1:0]   others_s;
    logic [IDW-1:0] next_ptr_s;

    // First requester at or after start, walking upward modulo N.
    function automatic logic [IDW-1:0] search(input logic [N-1:0] req, input logic [IDW-1:0] start);
        logic [IDW-1:0] idx;
        logic [IDW-1:0] jj;
        logic           found;
        int             j;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            if (j >= N) begin
                j = j - N;
            end else begin
                j = j;
            end
            jj = IDW'(j);
            if (!found && req[jj]) begin
                idx   = jj;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return idx;
    endfunction

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
        int t;
        t = int'(i) + 1;
        if (t >= N) begin
            t = 0;
        end else begin
            t = t;
        end
        return IDW'(t);
    endfunction

    assign others_s   = request & ~grant_q;
    assign next_ptr_s = wrap_inc(owner_q);

    // Next-state: grant selection, release handover, forced rotation and hold counting.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        expired_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|request) begin
                    state_d = S_GRANT;
                    owner_d = search(request, ptr_q);
                    hold_d  = HW'(1);
                    valid_d = 1'b1;
                end else begin
                    owner_d = '0;
                    valid_d = 1'b0;
                end
            end
            S_GRANT: begin
                if (!request[owner_q]) begin
                    ptr_d = next_ptr_s;
                    if (|request) begin
                        owner_d = search(request, next_ptr_s);
                        hold_d  = HW'(1);
                        valid_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        owner_d = '0;
                        hold_d  = '0;
                        valid_d = 1'b0;
                    end
                end else if ((MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD)) && (|others_s)) begin
                    ptr_d     = next_ptr_s;
                    owner_d   = search(others_s, next_ptr_s);
                    hold_d    = HW'(1);
                    expired_d = 1'b1;
                end else if ((MAX_HOLD != 0) && (hold_q < HW'(MAX_HOLD))) begin
                    hold_d = hold_q + HW'(1);
                end else begin
                    hold_d = hold_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                owner_d = '0;
                hold_d  = '0;
                valid_d = 1'b0;
            end
        endcase
        if (valid_d) begin
            grant_d = {{(N-1){1'b0}}, 1'b1} << owner_d;
        end else begin
            grant_d = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            hold_q    <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            expired_q <= expired_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = owner_q;
    assign grant_valid = valid_q;
    assign expired     = expired_q;

endmodule

// File: tb/tb_arbiter_rr_n.sv
// Scoreboard bench: a behavioural owner/pointer model predicts each cycle's grant,
// a monitor compares DUT outputs; a second N=2, MAX_HOLD=0 instance checks compatibility.
module tb_arbiter_rr_n;

    localparam int N  = 4;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gid;
    logic       gv;
    logic       gexp;

    logic       rst2;
    logic [1:0] req2;
    logic [1:0] gnt2;
    logic [0:0] gid2;
    logic       gv2;
    logic       gexp2;

    always #5 clk = ~clk;

    arbiter_rr_n #(.N(N), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .request(req), .grant(gnt),
        .grant_id(gid), .grant_valid(gv), .expired(gexp)
    );

    arbiter_rr_n #(.N(2), .MAX_HOLD(0)) dut2 (
        .clk(clk), .rst(rst2), .request(req2), .grant(gnt2),
        .grant_id(gid2), .grant_valid(gv2), .expired(gexp2)
    );

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic       v;
        logic       e;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   done2 = 1'b0;

    // model state: owner index (-1 = none), priority pointer, consecutive grant cycles
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    function automatic int pick(int r, int start);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (((r >> j) & 1) != 0) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input bit r, input logic [3:0] rq);
        int   rqi;
        int   oth;
        bit   ex;
        exp_t e;
        rqi = int'(rq);
        ex  = 1'b0;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_hold = 0;
        end else if (m_owner < 0) begin
            if (rqi != 0) begin
                m_owner = pick(rqi, m_ptr); m_hold = 1;
            end
        end else begin
            oth = rqi & ~(1 << m_owner);
            if (((rqi >> m_owner) & 1) == 0) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = pick(rqi, m_ptr);
                m_hold  = (m_owner < 0) ? 0 : 1;
            end else if (MH != 0 && m_hold == MH && oth != 0) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = pick(oth, m_ptr);
                m_hold  = 1;
                ex      = 1'b1;
            end else if (m_hold < MH) begin
                m_hold++;
            end
        end
        e.g  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        e.id = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        e.v  = (m_owner >= 0);
        e.e  = ex;
        sb_q.push_back(e);
    endtask

    task automatic step(input bit r, input logic [3:0] rq);
        @(negedge clk);
        rst = r;
        req = rq;
        @(posedge clk);
        cyc++;
        model_step(r, rq);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
        end
    endtask

    // monitor: compare every scored cycle just after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (gnt !== e.g || gid !== e.id || gv !== e.v || gexp !== e.e || !$onehot0(gnt)) begin
                n_err++;
                $display("FAIL scoreboard cyc=%0d got g=%b id=%0d v=%b e=%b want g=%b id=%0d v=%b e=%b",
                         cyc, gnt, gid, gv, gexp, e.g, e.id, e.v, e.e);
            end
        end
    end

    logic [3:0] fair_req [9] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
                                 4'b1111, 4'b1011, 4'b1111, 4'b0111};
    logic [3:0] fair_gnt [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                 4'b0100, 4'b1000, 4'b1000, 4'b0001};

    initial begin
        logic [3:0] cur;
        rst = 1'b1;
        req = 4'b1111;
        // reset with all requesting, then first grant to 0
        step(1'b1, 4'b1111);
        step(1'b1, 4'b1111);
        #2 chk("reset_grant", 32'(gnt), 32'h0);
        step(1'b0, 4'b1111);
        #2 chk("first_grant", 32'(gnt), 32'h1);

        // single lone requester holds indefinitely
        step(1'b1, 4'b0000);
        for (int i = 0; i < 21; i++) step(1'b0, 4'b0100);
        #2 chk("single_hold", 32'({gnt, gid, gexp}), 32'({4'b0100, 2'd2, 1'b0}));
        step(1'b0, 4'b0000);
        #2 chk("single_drop", 32'(gnt), 32'h0);

        // round-robin order 0,1,2,3,0 with no bubbles
        step(1'b1, 4'b0000);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, fair_req[i]);
            #2 chk("fair_order", 32'(gnt), 32'(fair_gnt[i]));
        end

        // forced rotation after exactly MH cycles
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        #2 chk("rot_hold", 32'(gnt), 32'h2);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b1010);
        step(1'b0, 4'b1010);
        #2 chk("rot_hold4", 32'({gnt, gexp}), 32'({4'b0010, 1'b0}));
        step(1'b0, 4'b1010);
        #2 chk("rot_forced", 32'({gnt, gexp}), 32'({4'b1000, 1'b1}));

        // reset mid-grant restores pointer to 0
        step(1'b1, 4'b1010);
        #2 chk("midrst_grant", 32'(gnt), 32'h0);
        step(1'b0, 4'b1001);
        #2 chk("midrst_ptr", 32'(gnt), 32'h1);

        // randomized traffic with sticky requests and occasional reset
        cur = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(5) == 0) cur[b] = ~cur[b];
            end
            step(($urandom_range(299) == 0), cur);
        end

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        chk("n2_done", 32'(done2), 32'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // N=2, MAX_HOLD=0: no rotation while both request
    initial begin
        rst2 = 1'b1;
        req2 = 2'b00;
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
        req2 = 2'b01;
        @(posedge clk);
        @(posedge clk);
        #1 chk("n2_grant", 32'({gnt2, gid2, gv2}), 32'({2'b01, 1'b0, 1'b1}));
        @(negedge clk);
        req2 = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 chk("n2_norot", 32'({gnt2, gexp2}), 32'({2'b01, 1'b0}));
        end
        @(negedge clk);
        req2 = 2'b10;
        @(posedge clk);
        #1 chk("n2_handover", 32'({gnt2, gid2}), 32'({2'b10, 1'b1}));
        done2 = 1'b1;
    end

endmodule
